// File: rtl/dac_frame_ctrl_if.sv
// Sample-producer side of the DAC frame sequencer: start/ready request handshake
// plus busy/done status.
// A sample transfers in exactly the clk where start && ready are both high. sample
// must be stable in that clk. start while ready is low is ignored.
interface dac_frame_ctrl_if;
    logic        start;
    logic [11:0] sample;
    logic        ready;
    logic        busy;
    logic        done;

    modport master (output start, output sample, input ready, input busy, input done);
    modport slave  (input start, input sample, output ready, output busy, output done);
endinterface

// File: rtl/dac_frame_ctrl.sv
// DAC frame sequencer: free-running sclk divider, sync_n framing and load/shift
// select for a negedge-clocked 16-bit shift register, one sample per frame.
module dac_frame_ctrl #(
    parameter int DIV_HALF   = 2,
    parameter int FRAME_BITS = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dac_frame_ctrl_if.slave   bus,
    output logic              sclk,
    output logic              sync_n,
    output logic              desp_enable,
    output logic [11:0]       data_out,
    output logic [1:0]        state_dbg
);
    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            busy_r;
    logic            div_wrap, rise_tick, bit_last, gap_last;
    logic            ready_i, done_i, accept, in_frame;

    assign div_wrap  = (div_cnt == DW'(DIV_HALF - 1));
    assign rise_tick = div_wrap && !sclk;
    assign bit_last  = (bit_cnt == BW'(FRAME_BITS - 1));
    assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Every transition waits for rise_tick, so control settles half a period before each sclk fall.
    always_comb begin
        state_nxt = state;
        if (rise_tick) begin
            case (state)
                IDLE:    if (busy_r)   state_nxt = LOAD;
                LOAD:                  state_nxt = SHIFT;
                SHIFT:   if (bit_last) state_nxt = GAP;
                GAP:     if (gap_last) state_nxt = IDLE;
                default:               state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_i  = (state == IDLE) && !busy_r;
        done_i   = rise_tick && (state == GAP) && gap_last;
        accept   = bus.start && ready_i;
        in_frame = (state_nxt == SHIFT);
    end

    assign bus.ready = ready_i;
    assign bus.done  = done_i;
    assign bus.busy  = busy_r;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_n      <= 1'b1;
            desp_enable <= 1'b0;
        end else if (rise_tick) begin
            sync_n      <= !in_frame;
            desp_enable <= in_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (rise_tick) begin
            if (state == LOAD)
                bit_cnt <= '0;
            else if (state == SHIFT)
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            if (state == SHIFT && bit_last)
                gap_cnt <= '0;
            else if (state == GAP)
                gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
        end
    end

    // data_out only moves on acceptance, which cannot happen while a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            busy_r   <= 1'b1;
            data_out <= bus.sample;
        end else if (done_i) begin
            busy_r   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Directed bench for dac_frame_ctrl: three instances (DIV_HALF 2, 1, 5) with a
// negedge shift-register model and frame/edge monitors per instance.
module tb_dac_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_frame_ctrl_if bus0 ();
    dac_frame_ctrl_if bus1 ();
    dac_frame_ctrl_if bus5 ();

    logic        sclk0, sync0, desp0, sclk1, sync1, desp1, sclk5, sync5, desp5;
    logic [11:0] dout0, dout1, dout5;
    logic [1:0]  st0, st1, st5;

    dac_frame_ctrl #(.DIV_HALF(2), .FRAME_BITS(16), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sclk(sclk0), .sync_n(sync0),
        .desp_enable(desp0), .data_out(dout0), .state_dbg(st0));
    dac_frame_ctrl #(.DIV_HALF(1), .FRAME_BITS(16), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sclk(sclk1), .sync_n(sync1),
        .desp_enable(desp1), .data_out(dout1), .state_dbg(st1));
    dac_frame_ctrl #(.DIV_HALF(5), .FRAME_BITS(16), .GAP_CYCLES(2)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .sclk(sclk5), .sync_n(sync5),
        .desp_enable(desp5), .data_out(dout5), .state_dbg(st5));

    localparam int DIVS [3] = '{2, 1, 5};

    logic        sclk_w [3], sync_w [3], desp_w [3], done_w [3];
    logic [11:0] dout_w [3];
    assign sclk_w[0] = sclk0;  assign sclk_w[1] = sclk1;  assign sclk_w[2] = sclk5;
    assign sync_w[0] = sync0;  assign sync_w[1] = sync1;  assign sync_w[2] = sync5;
    assign desp_w[0] = desp0;  assign desp_w[1] = desp1;  assign desp_w[2] = desp5;
    assign done_w[0] = bus0.done; assign done_w[1] = bus1.done; assign done_w[2] = bus5.done;
    assign dout_w[0] = dout0;  assign dout_w[1] = dout1;  assign dout_w[2] = dout5;

    // Monitor state, per instance
    logic [15:0] sr_m [3], cap_m [3], word_m [3];
    int          nbits_m [3], bits_m [3], lowc_m [3], lowlen_m [3], highc_m [3], highlen_m [3];
    int          frames_m [3], dones_m [3], edge_bad [3], period_bad [3], last_rise [3], last_period [3];
    logic        have_rise [3], p_sclk [3], p_sync [3], p_desp [3];
    int          cyc = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            sr_m[i] = '0; cap_m[i] = '0; word_m[i] = '0;
            nbits_m[i] = 0; bits_m[i] = 0; lowc_m[i] = 0; lowlen_m[i] = 0;
            highc_m[i] = 0; highlen_m[i] = 0; frames_m[i] = 0; dones_m[i] = 0;
            edge_bad[i] = 0; period_bad[i] = 0; last_rise[i] = 0; last_period[i] = 0;
            have_rise[i] = 1'b0; p_sclk[i] = 1'b0; p_sync[i] = 1'b1; p_desp[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                p_sclk[i]    <= 1'b0;
                p_sync[i]    <= 1'b1;
                p_desp[i]    <= 1'b0;
                have_rise[i] <= 1'b0;
            end else begin
                p_sclk[i] <= sclk_w[i];
                p_sync[i] <= sync_w[i];
                p_desp[i] <= desp_w[i];
                if ((sync_w[i] !== p_sync[i] || desp_w[i] !== p_desp[i]) && !(sclk_w[i] && !p_sclk[i]))
                    edge_bad[i] <= edge_bad[i] + 1;
                if (sclk_w[i] && !p_sclk[i]) begin
                    if (have_rise[i]) begin
                        last_period[i] <= cyc - last_rise[i];
                        if (cyc - last_rise[i] != 2 * DIVS[i]) period_bad[i] <= period_bad[i] + 1;
                    end
                    have_rise[i] <= 1'b1;
                    last_rise[i] <= cyc;
                end
                // Shift register: falling sclk loads or shifts; DAC samples the MSB while sync_n is low.
                if (!sclk_w[i] && p_sclk[i]) begin
                    if (!sync_w[i]) begin
                        cap_m[i]   <= {cap_m[i][14:0], sr_m[i][15]};
                        nbits_m[i] <= nbits_m[i] + 1;
                    end
                    sr_m[i] <= desp_w[i] ? {sr_m[i][14:0], 1'b0} : {4'b0000, dout_w[i]};
                end
                if (!sync_w[i]) begin
                    if (p_sync[i]) begin
                        frames_m[i]  <= frames_m[i] + 1;
                        nbits_m[i]   <= 0;
                        cap_m[i]     <= '0;
                        lowc_m[i]    <= 1;
                        highlen_m[i] <= highc_m[i];
                    end else begin
                        lowc_m[i] <= lowc_m[i] + 1;
                    end
                end else begin
                    if (!p_sync[i]) begin
                        word_m[i]   <= cap_m[i];
                        bits_m[i]   <= nbits_m[i];
                        lowlen_m[i] <= lowc_m[i];
                        highc_m[i]  <= 1;
                    end else begin
                        highc_m[i] <= highc_m[i] + 1;
                    end
                end
                if (done_w[i]) dones_m[i] <= dones_m[i] + 1;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int i);
        case (i)
            0:       return bus0.ready;
            1:       return bus1.ready;
            default: return bus5.ready;
        endcase
    endfunction

    function automatic logic dn(input int i);
        case (i)
            0:       return bus0.done;
            1:       return bus1.done;
            default: return bus5.done;
        endcase
    endfunction

    task automatic drive(input int i, input logic s, input logic [11:0] v);
        case (i)
            0:       begin bus0.start = s; bus0.sample = v; end
            1:       begin bus1.start = s; bus1.sample = v; end
            default: begin bus5.start = s; bus5.sample = v; end
        endcase
    endtask

    task automatic send(input int i, input logic [11:0] v);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy(i) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", {31'd0, rdy(i)}, 32'd1);
        drive(i, 1'b1, v);
        @(posedge clk);
        #1 drive(i, 1'b0, v);
    endtask

    task automatic wait_done(input int i, input int budget, output int used);
        used = 0;
        while (!dn(i) && used < budget) begin
            @(negedge clk);
            used++;
        end
        check("done_seen", {31'd0, dn(i)}, 32'd1);
    endtask

    task automatic wait_sync_low(input int bound);
        int t;
        t = 0;
        while (sync0 !== 1'b0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        check("sync_low_seen", {31'd0, sync0}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        check(tag, {14'd0, st0, sclk0, sync0, desp0, dout0, bus0.busy, bus0.done, bus0.ready},
                   {14'd0, 2'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int c, f0, d0, f1, f5;
        drive(0, 1'b0, 12'h000);
        drive(1, 1'b0, 12'h000);
        drive(2, 1'b0, 12'h000);
        #12;
        chk_reset("reset_state");
        @(negedge clk);
        #2 rst = 1'b0;

        // Single frame
        f0 = frames_m[0]; d0 = dones_m[0];
        send(0, 12'hA5C);
        wait_done(0, 200, c);
        check("a5c_latency_ok", {31'd0, c <= 84}, 32'd1);
        check("a5c_ready_at_done", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk);
        check("a5c_ready_after", {31'd0, bus0.ready}, 32'd1);
        check("a5c_word", {16'd0, word_m[0]}, 32'h0A5C);
        check("a5c_bits", bits_m[0], 16);
        check("a5c_low_len", lowlen_m[0], 64);
        check("a5c_frames", frames_m[0] - f0, 1);
        check("a5c_dones", dones_m[0] - d0, 1);

        // Full scale and zero
        send(0, 12'hFFF);
        wait_done(0, 200, c);
        @(negedge clk);
        check("fff_word", {16'd0, word_m[0]}, 32'h0FFF);
        check("fff_bits", bits_m[0], 16);
        send(0, 12'h000);
        wait_done(0, 200, c);
        @(negedge clk);
        check("zero_word", {16'd0, word_m[0]}, 32'h0000);
        check("zero_bits", bits_m[0], 16);

        // Back-to-back with start held high
        f0 = frames_m[0];
        @(negedge clk);
        drive(0, 1'b1, 12'h123);
        @(posedge clk);
        #1 drive(0, 1'b1, 12'h456);
        check("b2b_first_data", {20'd0, dout0}, 32'h123);
        wait_done(0, 200, c);
        check("b2b_ready_at_done", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk);
        check("b2b_not_early", {20'd0, dout0}, 32'h123);
        check("b2b_ready_after", {31'd0, bus0.ready}, 32'd1);
        check("b2b_first_word", {16'd0, word_m[0]}, 32'h0123);
        @(posedge clk);
        #1;
        check("b2b_second_accept", {19'd0, bus0.busy, dout0}, {19'd0, 1'b1, 12'h456});
        drive(0, 1'b0, 12'h456);
        wait_done(0, 200, c);
        @(negedge clk);
        check("b2b_second_word", {16'd0, word_m[0]}, 32'h0456);
        check("b2b_gap_len", highlen_m[0], 16);
        check("b2b_frames", frames_m[0] - f0, 2);

        // Request during SHIFT is ignored
        f0 = frames_m[0];
        send(0, 12'h111);
        wait_sync_low(100);
        repeat (6) @(negedge clk);
        drive(0, 1'b1, 12'h777);
        @(posedge clk);
        #1 drive(0, 1'b0, 12'h777);
        check("ign_data_hold", {20'd0, dout0}, 32'h111);
        wait_done(0, 200, c);
        @(negedge clk);
        check("ign_word", {16'd0, word_m[0]}, 32'h0111);
        repeat (60) @(negedge clk);
        check("ign_frames", frames_m[0] - f0, 1);
        check("ign_idle", {19'd0, bus0.busy, dout0}, {19'd0, 1'b0, 12'h111});

        // Reset mid-SHIFT
        d0 = dones_m[0];
        send(0, 12'h3C3);
        wait_sync_low(100);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("reset_mid_shift");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rst_no_done", dones_m[0] - d0, 0);
        check("rst_period", last_period[0], 4);
        check("rst_period_bad", period_bad[0], 0);
        check("rst_stays_idle", {30'd0, sync0, bus0.ready}, {30'd0, 1'b1, 1'b1});

        // Divider sweep
        f1 = frames_m[1]; f5 = frames_m[2];
        send(1, 12'hC3A);
        send(2, 12'hC3A);
        wait_done(1, 200, c);
        wait_done(2, 400, c);
        @(negedge clk);
        check("div1_word", {16'd0, word_m[1]}, 32'h0C3A);
        check("div5_word", {16'd0, word_m[2]}, 32'h0C3A);
        check("div1_low_len", lowlen_m[1], 32);
        check("div5_low_len", lowlen_m[2], 160);
        check("div1_period", last_period[1], 2);
        check("div5_period", last_period[2], 10);
        check("div1_frames", frames_m[1] - f1, 1);
        check("div5_frames", frames_m[2] - f5, 1);
        check("div1_period_bad", period_bad[1], 0);
        check("div5_period_bad", period_bad[2], 0);
        check("div2_edge_bad", edge_bad[0], 0);
        check("div1_edge_bad", edge_bad[1], 0);
        check("div5_edge_bad", edge_bad[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_frame_ctrl.md
Name: dac_frame_ctrl

Overview:
Sequencer for the 16-bit serial DAC shift register: generates the DAC serial clock (sclk) from the system clock, frames each conversion with sync_n, and drives the shift register's load/shift select (desp_enable) and 12-bit parallel word.
- Sits between the sample producer (start/ready handshake) and the shift register plus external DAC pins.
- One sample per frame: 16 bits MSB-first, 4 leading zeros then the 12-bit sample.

Parameters:
- DIV_HALF, 2: clk cycles per sclk half-period; legal range ≥ 1.
- FRAME_BITS, 16: sclk falling edges per frame with sync_n low.
- GAP_CYCLES, 2: sclk periods with sync_n high after each frame; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to convert sample; accepted only when start&&ready.
- sample  input  12  sample value, captured on acceptance.
- ready  output  1  high when a new sample can be accepted.
- sclk  output  1  DAC serial clock; shift register is clocked on its falling edge.
- sync_n  output  1  DAC frame select, active low.
- desp_enable  output  1  0 = shift register loads data_out; 1 = shift register shifts.
- data_out  output  12  held sample driven to the shift register's parallel input.
- busy  output  1  high from acceptance until done.
- done  output  1  one-clk pulse at end of frame gap.

Behaviour:
- Reset values (async, immediate):
  - outputs: sclk=0, sync_n=1, desp_enable=0, data_out=0, busy=0, done=0, ready=1;
  - internal: divider counter=0, state=IDLE, bit counter=0, gap counter=0.
- Reset mid-frame aborts the frame with no done pulse.
- sclk generation:
  - Free-running after reset; toggles every DIV_HALF clk cycles; period = 2*DIV_HALF clks.
  - rise_tick = the clk cycle in which sclk is registered 0→1.
  - All FSM transitions and sync_n/desp_enable changes occur only on rise_tick. Control is therefore stable a half-period before every falling edge, with no race against the negedge shift register.
- Handshake:
  - ready = (state==IDLE) && !busy.
  - On start&&ready: data_out<=sample, busy<=1, ready drops the next clk.
  - start while not ready is ignored, and data_out is unchanged.
- FSM states and transitions:
  - IDLE: sync_n=1, desp_enable=0. On rise_tick with busy=1 → LOAD.
  - LOAD: sync_n=1, desp_enable=0. The following sclk fall loads {4'b0,data_out}. Next rise_tick → SHIFT with sync_n=0, desp_enable=1, bit counter=0.
  - SHIFT: sync_n=0, desp_enable=1.
    - Each rise_tick increments the bit counter.
    - On the rise_tick where the counter reaches FRAME_BITS → GAP with sync_n=1, desp_enable=0.
    - Exactly FRAME_BITS sclk falls occur with sync_n low. Fall k presents bit 16-k on the serial output (k=1 gives bit 15).
  - GAP: sync_n=1, desp_enable=0.
    - Counts GAP_CYCLES rise_ticks.
    - On the last one: done=1 for one clk, busy=0, → IDLE.
- Latency:
  - Acceptance to sync_n falling: first rise_tick after acceptance plus one sclk period.
  - Acceptance to done: ≤ (2 + FRAME_BITS + GAP_CYCLES) sclk periods + 2*DIV_HALF clks.
- Boundary conditions:
  - start asserted in the same clk as done: not accepted, since ready is still 0. It is accepted the next clk.
  - start asserted in the same clk as a rise_tick in IDLE: captured. LOAD is entered on the next rise_tick, not the current one.
  - data_out is constant for the whole frame regardless of sample/start activity.
  - sync_n never glitches: it is registered and changes only on rise_tick.

Test Plan:
- Reset check: DIV_HALF=2. Assert rst mid-SHIFT → all outputs return to their reset values immediately; after release, sclk resumes with period 4 clks; no done pulse.
- Single frame: sample=12'hA5C with start for 1 clk.
  - Data: the shift-register model's serial output sampled at the 16 sclk falls with sync_n low reads 16'h0A5C, MSB first.
  - Frame: sync_n is low for exactly 16 sclk periods.
  - Completion: done pulses once, then ready=1.
- Full scale and zero: sample=12'hFFF → stream 16'h0FFF; sample=12'h000 → 16'h0000. Each is preceded by exactly 4 zero bits.
- Back-to-back: start held high continuously with samples 12'h123 then 12'h456.
  - Exactly two frames, separated by sync_n high for GAP_CYCLES + 2 sclk periods (GAP, IDLE wait, LOAD).
  - Second sample accepted the clk after the first done.
- Ignored request: pulse start=1 with sample=12'h777 during SHIFT of a 12'h111 frame → frame streams 16'h0111, data_out stays 12'h111, no extra frame.
- Divider sweep: DIV_HALF=1 and 5.
  - sclk period is 2 and 10 clks respectively.
  - sync_n and desp_enable change only in rise_tick cycles.
  - Frame content is correct for 12'hC3A.
